// File: rtl/dual_port_mem_responder_if.sv
// Request/response bundle between the CPU's two memory buses and the shared-storage responder.
// Port 1 is the read-only fetch bus, port 2 the read/write data bus.
interface dual_port_mem_responder_if;
   logic        req1_valid;
   logic [31:0] req1_addr;
   logic        req1_ready;
   logic        rsp1_valid;
   logic [31:0] rsp1_data;
   logic        rsp1_err;

   logic        req2_valid;
   logic        req2_write;
   logic [31:0] req2_addr;
   logic [31:0] req2_wdata;
   logic        req2_ready;
   logic        rsp2_valid;
   logic [31:0] rsp2_rdata;
   logic        rsp2_err;

   modport master (
      output req1_valid, req1_addr,
      output req2_valid, req2_write, req2_addr, req2_wdata,
      input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
      input  req2_ready, rsp2_valid, rsp2_rdata, rsp2_err
   );

   modport slave (
      input  req1_valid, req1_addr,
      input  req2_valid, req2_write, req2_addr, req2_wdata,
      output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
      output req2_ready, rsp2_valid, rsp2_rdata, rsp2_err
   );
endinterface

// File: rtl/dual_port_mem_responder.sv
// Two-port memory responder over one byte array: round-robin arbitration, programmable
// wait states, one-cycle response pulse, alignment/range error reporting.
module dual_port_mem_responder #(
   parameter int unsigned NUM_BYTES = 64,
   parameter int unsigned LATENCY   = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   dual_port_mem_responder_if.slave        bus
);
   localparam int unsigned AW        = $clog2(NUM_BYTES);
   localparam int unsigned CW        = 4;
   localparam logic [31:0] MAX_ADDR  = 32'(NUM_BYTES - 4);
   localparam bit          ZERO_LAT  = (LATENCY == 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_last_p2;
   logic          r_port2;
   logic          r_write;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [7:0]    r_mem [NUM_BYTES];

   logic          r_rsp1_valid, r_rsp1_err;
   logic [31:0]   r_rsp1_data;
   logic          r_rsp2_valid, r_rsp2_err;
   logic [31:0]   r_rsp2_data;

   logic          w_ready1, w_ready2, w_accept, w_enter_resp;
   logic          w_txn_p2, w_txn_write, w_txn_err;
   logic [31:0]   w_txn_addr, w_txn_wdata, w_rd_word;
   logic [AW-1:0] w_idx;

   // Arbitration: single requester wins; on contention the port not granted last time wins
   always_comb begin
      w_ready1 = 1'b0;
      w_ready2 = 1'b0;
      if (reset && (r_state == S_IDLE)) begin
         if (bus.req1_valid && bus.req2_valid) begin
            w_ready1 = r_last_p2;
            w_ready2 = !r_last_p2;
         end else begin
            w_ready1 = bus.req1_valid;
            w_ready2 = bus.req2_valid;
         end
      end
   end

   assign w_accept = (w_ready1 & bus.req1_valid) | (w_ready2 & bus.req2_valid);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cnt_nxt   = CW'(LATENCY);
               w_state_nxt = ZERO_LAT ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) w_state_nxt = S_RESP;
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

   // With zero wait states the response edge is the accept edge, so take the live request
   assign w_txn_p2    = (r_state == S_IDLE) ? w_ready2 : r_port2;
   assign w_txn_addr  = (r_state == S_IDLE) ? (w_ready2 ? bus.req2_addr : bus.req1_addr) : r_addr;
   assign w_txn_wdata = (r_state == S_IDLE) ? bus.req2_wdata : r_wdata;
   assign w_txn_write = (r_state == S_IDLE) ? (w_ready2 & bus.req2_write) : r_write;
   assign w_txn_err   = (w_txn_addr[1:0] != 2'b00) || (w_txn_addr > MAX_ADDR);
   assign w_idx       = w_txn_addr[AW-1:0];

   always_comb begin
      w_rd_word = '0;
      for (int unsigned k = 0; k < 4; k++)
         w_rd_word[8*k +: 8] = r_mem[w_idx + AW'(k)];
   end

   // Storage is not reset; commits only on the edge entering RESP for a legal write
   always_ff @(posedge clk) begin
      if (w_enter_resp && w_txn_write && !w_txn_err) begin
         for (int unsigned k = 0; k < 4; k++)
            r_mem[w_idx + AW'(k)] <= w_txn_wdata[8*k +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_last_p2 <= 1'b0;
         r_port2   <= 1'b0;
         r_write   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_last_p2 <= w_ready2;
            r_port2   <= w_ready2;
            r_write   <= w_txn_write;
            r_addr    <= w_txn_addr;
            r_wdata   <= bus.req2_wdata;
         end
      end
   end

   // Response pulse; data/err hold between pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp1_valid <= 1'b0;
         r_rsp1_err   <= 1'b0;
         r_rsp1_data  <= '0;
         r_rsp2_valid <= 1'b0;
         r_rsp2_err   <= 1'b0;
         r_rsp2_data  <= '0;
      end else begin
         r_rsp1_valid <= 1'b0;
         r_rsp2_valid <= 1'b0;
         if (w_enter_resp) begin
            if (w_txn_p2) begin
               r_rsp2_valid <= 1'b1;
               r_rsp2_err   <= w_txn_err;
               r_rsp2_data  <= (w_txn_err || w_txn_write) ? 32'h0 : w_rd_word;
            end else begin
               r_rsp1_valid <= 1'b1;
               r_rsp1_err   <= w_txn_err;
               r_rsp1_data  <= w_txn_err ? 32'h0 : w_rd_word;
            end
         end
      end
   end

   assign bus.req1_ready = w_ready1;
   assign bus.req2_ready = w_ready2;
   assign bus.rsp1_valid = r_rsp1_valid;
   assign bus.rsp1_data  = r_rsp1_data;
   assign bus.rsp1_err   = r_rsp1_err;
   assign bus.rsp2_valid = r_rsp2_valid;
   assign bus.rsp2_rdata = r_rsp2_data;
   assign bus.rsp2_err   = r_rsp2_err;
endmodule
